// File: rtl/neopixel_chain_tx.sv
// Serialises a frame of NBR_PIXELS pixel words onto a single NeoPixel data line,
// followed by a latch gap; a one-entry holding register keeps the bit stream gap-free.
module neopixel_chain_tx #(
  parameter int NBR_PIXELS     = 8,
  parameter int BITS_PER_PIXEL = 24,
  parameter int T0H            = 6,
  parameter int T1H            = 13,
  parameter int TBIT           = 20,
  parameter int TLATCH         = 1280
) (
  input  logic                      clk_16MHz,
  input  logic                      rst,
  input  logic                      start_tx,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      dout,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun,
  output logic [2:0]                dbg_state
);

  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int BW = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int LW = (TLATCH > 1) ? $clog2(TLATCH) : 1;
  localparam int SW = (NBR_PIXELS > 1) ? $clog2(NBR_PIXELS) : 1;
  localparam int AW = $clog2(NBR_PIXELS + 1);

  localparam logic [CW-1:0] BIT_CYC_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] HI_ONE       = CW'(T1H);
  localparam logic [CW-1:0] HI_ZERO      = CW'(T0H);
  localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_PIXEL - 1);
  localparam logic [LW-1:0] LATCH_LAST   = LW'(TLATCH - 1);
  localparam logic [SW-1:0] PIX_LAST     = SW'(NBR_PIXELS - 1);
  localparam logic [AW-1:0] PIX_TOTAL    = AW'(NBR_PIXELS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIRST = 3'd1,
    SEND       = 3'd2,
    LATCH      = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [BITS_PER_PIXEL-1:0] shift_q;
  logic [BITS_PER_PIXEL-1:0] hold_q;
  logic                      hold_full;
  logic [CW-1:0]             bit_cnt;
  logic [BW-1:0]             bit_idx;
  logic [LW-1:0]             latch_cnt;
  logic [SW-1:0]             sent_cnt;
  logic [AW-1:0]             acc_cnt;

  logic hs;
  logic bit_end;
  logic pix_end;
  logic last_pix;

  // Handshake: a pixel word transfers on a rising edge where pix_valid and
  // pix_ready are both high; pix_data is captured on that same edge.
  assign hs       = pix_valid && pix_ready;
  assign bit_end  = (bit_cnt == BIT_CYC_LAST);
  assign pix_end  = bit_end && (bit_idx == BIT_LAST);
  assign last_pix = (sent_cnt == PIX_LAST);

  always_ff @(posedge clk_16MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pix_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start_tx) state_nx = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        pix_ready = 1'b1;
        if (pix_valid) state_nx = SEND;
      end
      SEND: begin
        // A full holding register keeps ready low, so it can never refill on the drain edge.
        pix_ready = !hold_full && (acc_cnt < PIX_TOTAL);
        if (pix_end && (last_pix || !(hold_full || (pix_valid && pix_ready))))
          state_nx = LATCH;
      end
      LATCH: begin
        if (latch_cnt == LATCH_LAST) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk_16MHz) begin
    if (rst) begin
      dout      <= 1'b0;
      underrun  <= 1'b0;
      shift_q   <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      latch_cnt <= '0;
      sent_cnt  <= '0;
      acc_cnt   <= '0;
    end else begin
      dout <= (state == SEND) &&
              (bit_cnt < (shift_q[BITS_PER_PIXEL-1] ? HI_ONE : HI_ZERO));
      case (state)
        IDLE: begin
          if (start_tx) begin
            underrun  <= 1'b0;
            hold_full <= 1'b0;
            acc_cnt   <= '0;
            sent_cnt  <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            latch_cnt <= '0;
          end
        end
        WAIT_FIRST: begin
          if (hs) begin
            shift_q <= pix_data;
            acc_cnt <= acc_cnt + 1'b1;
          end
        end
        SEND: begin
          if (hs) acc_cnt <= acc_cnt + 1'b1;
          if (hs && !pix_end) begin
            hold_q    <= pix_data;
            hold_full <= 1'b1;
          end
          if (bit_end) begin
            bit_cnt <= '0;
            if (pix_end) begin
              bit_idx <= '0;
              if (!last_pix) sent_cnt <= sent_cnt + 1'b1;
              // Next pixel comes from the holding register, or straight from the
              // port when it arrives exactly on the pixel boundary.
              if (hold_full) begin
                shift_q   <= hold_q;
                hold_full <= 1'b0;
              end else if (hs) begin
                shift_q <= pix_data;
              end else if (!last_pix) begin
                underrun <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift_q <= shift_q << 1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) latch_cnt <= '0;
          else                         latch_cnt <= latch_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/neopixel_chain_tx.md
NEOPIXEL_CHAIN_TX -- requirements
Module: neopixel_chain_tx

Interface
REQ-001 Parameter NBR_PIXELS, default 8, pixels per frame (>=1).
REQ-002 Parameter BITS_PER_PIXEL, default 24, bits per pixel (24 = GRB, 32 = GRBW); other values illegal.
REQ-003 Parameter T0H, default 6, high-time cycles for a 0 bit.
REQ-004 Parameter T1H, default 13, high-time cycles for a 1 bit.
REQ-005 Parameter TBIT, default 20, total cycles per bit; 0 < T0H < T1H < TBIT.
REQ-006 Parameter TLATCH, default 1280, low cycles closing a frame (80 us at 16 MHz).
REQ-007 clk_16MHz  input  1  sole clock, all logic on its rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 start_tx  input  1  frame request, sampled only in IDLE.
REQ-010 pix_data  input  BITS_PER_PIXEL  next pixel word, transmitted MSB first.
REQ-011 pix_valid  input  1  pix_data valid.
REQ-012 pix_ready  output  1  block accepts pix_data this cycle.
REQ-013 dout  output  1  registered serial line to the pixel chain.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at frame completion.
REQ-016 underrun  output  1  sticky: frame truncated for lack of data.

Function
REQ-017 States SHALL be IDLE, WAIT_FIRST, SEND, LATCH, DONE.
REQ-018 IDLE: dout=0, pix_ready=0; start_tx=1 -> WAIT_FIRST next cycle, clear underrun, load accepted-pixel count 0.
REQ-019 WAIT_FIRST: pix_ready=1, dout=0, no timeout; on pix_valid&pix_ready load pixel into shift register -> SEND.
REQ-020 A handshake occurs only when pix_valid and pix_ready are both high on the same edge; pix_data is captured on that edge.
REQ-021 SEND: bit counter runs 0..TBIT-1; dout=1 while counter < T1H (bit=1) or < T0H (bit=0), else 0; each bit exactly TBIT cycles.
REQ-022 First dout rise SHALL occur on the edge after the first-pixel handshake; bits are back-to-back with no gap cycles.
REQ-023 One-entry holding register: in SEND pix_ready=1 while holding empty and accepted count < NBR_PIXELS; never high once NBR_PIXELS accepted.
REQ-024 End of a pixel's last bit with more pixels owed: holding full -> move to shift register, next bit starts the following cycle, no gap; holding empty -> set underrun, enter LATCH.
REQ-025 Handshake on the same edge the holding register drains SHALL NOT be permitted (pix_ready low that cycle).
REQ-026 End of the last bit of pixel NBR_PIXELS -> LATCH.
REQ-027 LATCH: dout=0 for exactly TLATCH cycles, then DONE.
REQ-028 DONE: done=1 for one cycle, then IDLE; start_tx held high restarts a frame from IDLE.
REQ-029 start_tx while busy SHALL be ignored.
REQ-030 Counters sized with $clog2 of their maximum; no wrap before their terminal value.

Reset
REQ-031 rst=1 on an edge: state IDLE, dout=0, pix_ready=0, busy=0, done=0, underrun=0, holding register empty, counters 0.
REQ-032 rst mid-frame SHALL abort immediately: dout low the following cycle, no done pulse, no latch period.
REQ-033 rst has priority over all other inputs.

Verification
REQ-034 NBR_PIXELS=1, pixel 24'h800001, valid always -> bit 0: 13 high/7 low; bits 1-22: 6 high/14 low; bit 23: 13 high/7 low; then 1280 low, done pulse, underrun=0.
REQ-035 NBR_PIXELS=3, data pre-supplied -> 72 contiguous bit periods (1440 cycles) with no gap, exactly 3 handshakes, pix_ready never high after third.
REQ-036 NBR_PIXELS=3, second pixel withheld until after pixel 1 ends -> underrun=1 after 24 bits, LATCH 1280 cycles, done pulse, underrun held until next start_tx.
REQ-037 BITS_PER_PIXEL=32, pixel 32'hFFFFFFFF -> 32 consecutive 13-high/7-low periods then latch.
REQ-038 rst asserted at bit 10 of pixel 2 -> dout=0 and busy=0 next cycle, done never pulses; fresh start_tx yields a correct frame.
REQ-039 start_tx pulsed during SEND and LATCH -> no effect; frame length and done timing unchanged.
